// File: rtl/moore_state_encoder.sv
`default_nettype none
// ============================================================================
// Module   : moore_state_encoder
// Purpose  : Next-state logic and state register of the Moore sequence
//            detector. Tracks how many leading bits of PATTERN are matched
//            (overlap allowed) and counts completed matches, saturating.
// Revision : 1.0  initial release
// ============================================================================
module moore_state_encoder #(
    parameter logic [7:0] PATTERN = 8'b11010011
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Clear,
    input  logic       In_Valid,
    input  logic       In_Bit,
    output logic [3:0] State,
    output logic [7:0] Match_Count
);

    localparam logic [3:0] c_S0      = 4'd0;
    localparam logic [3:0] c_S8      = 4'd8;
    localparam logic [7:0] c_CNT_MAX = 8'd255;

    logic [3:0] r_state;
    logic [7:0] r_count;
    logic [3:0] w_next;
    logic       w_illegal;

    // Longest suffix of (prefix(k) followed by b) that is also a prefix of
    // PATTERN, capped at 8. Works for any PATTERN value; k is assumed 0..8.
    function automatic logic [3:0] f_next(input logic [3:0] k, input logic b);
        logic [8:0] pfx;
        logic [8:0] w;
        logic [8:0] mask;
        logic [8:0] pre;
        logic [3:0] best;
        pfx  = {1'b0, PATTERN} >> (4'd8 - k);
        w    = {pfx[7:0], b};
        best = c_S0;
        for (int j = 1; j <= 8; j++) begin
            if (j <= int'(k) + 1) begin
                mask = (9'd1 << j) - 9'd1;
                pre  = {1'b0, PATTERN} >> (8 - j);
                if ((w & mask) == pre) begin
                    best = 4'(j);
                end
            end
        end
        return best;
    endfunction

    // Candidate next state and illegal-encoding detect
    always_comb begin
        w_illegal = (r_state > c_S8);
        w_next    = f_next(r_state, In_Bit);
    end

    // State and match-counter register: clear, illegal recovery, advance, hold
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_S0;
            r_count <= 8'd0;
        end else if (Clear) begin
            r_state <= c_S0;
            r_count <= 8'd0;
        end else if (w_illegal) begin
            r_state <= c_S0;
        end else if (In_Valid) begin
            r_state <= w_next;
            if ((w_next == c_S8) && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign State       = r_state;
    assign Match_Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_moore_state_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_moore_state_encoder
// Purpose  : Scoreboard bench for moore_state_encoder. Stimulus pushes the
//            hand-computed state/count into a queue; a monitor pops one entry
//            per cycle and compares. A second instance uses PATTERN=8'hFF.
// Revision : 1.0  initial release
// ============================================================================
module tb_moore_state_encoder;

    typedef struct {
        bit         sel;     // 0: default pattern instance, 1: 8'hFF instance
        logic [3:0] st;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       v0, b0, v1, b1;
    logic [3:0] st0, st1;
    logic [7:0] cnt0, cnt1;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;

    moore_state_encoder dut (
        .Clk(clk), .Reset_n(rst_n), .Clear(clear),
        .In_Valid(v0), .In_Bit(b0), .State(st0), .Match_Count(cnt0)
    );

    moore_state_encoder #(.PATTERN(8'hFF)) dut_ff (
        .Clk(clk), .Reset_n(rst_n), .Clear(clear),
        .In_Valid(v1), .In_Bit(b1), .State(st1), .Match_Count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: one expectation is due per falling edge after it was pushed
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.sel) begin
                check4({e.name, ".state"}, st1, e.st);
                check8({e.name, ".count"}, cnt1, e.cnt);
            end else begin
                check4({e.name, ".state"}, st0, e.st);
                check8({e.name, ".count"}, cnt0, e.cnt);
            end
        end
    end

    // Drive inputs for the coming rising edge and push its expected result
    task automatic drive_push(input bit sel, input logic clr, input logic v, input logic b,
                              input logic [3:0] es, input logic [7:0] ec, input string name);
        exp_t e;
        clear = clr;
        v0 = sel ? 1'b0 : v;
        b0 = sel ? 1'b0 : b;
        v1 = sel ? v : 1'b0;
        b1 = sel ? b : 1'b0;
        e.sel = sel; e.st = es; e.cnt = ec; e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic b, input logic [3:0] es,
                        input logic [7:0] ec, input string name);
        @(negedge clk); #1;
        drive_push(1'b0, 1'b0, v, b, es, ec, name);
    endtask

    // Feed the default pattern from S0; ends in S8 with count base+1
    task automatic full_match(input logic [7:0] base, input string name);
        logic [7:0] pat;
        pat = 8'b11010011;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pat[7-i], 4'(i + 1), (i == 7) ? base + 8'd1 : base, name);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; clear = 1'b0;
        v0 = 1'b0; b0 = 1'b0; v1 = 1'b0; b1 = 1'b0;
        #12;
        check4("reset.state", st0, 4'd0);
        check8("reset.count", cnt0, 8'd0);
        @(negedge clk); rst_n = 1'b1;

        // Full match and overlap
        full_match(8'd0, "full");
        step(1'b1, 1'b1, 4'd2, 8'd1, "ovl_s8_b1");
        step(1'b1, 1'b0, 4'd3, 8'd1, "re_s3");
        step(1'b1, 1'b1, 4'd4, 8'd1, "re_s4");
        step(1'b1, 1'b0, 4'd5, 8'd1, "re_s5");
        step(1'b1, 1'b0, 4'd6, 8'd1, "re_s6");
        step(1'b1, 1'b1, 4'd7, 8'd1, "re_s7");
        step(1'b1, 1'b1, 4'd8, 8'd2, "re_s8");
        step(1'b1, 1'b0, 4'd3, 8'd2, "ovl_s8_b0");
        step(1'b1, 1'b1, 4'd4, 8'd2, "ovl_s4");
        step(1'b1, 1'b0, 4'd5, 8'd2, "ovl_s5");
        step(1'b1, 1'b0, 4'd6, 8'd2, "ovl_s6");
        step(1'b1, 1'b1, 4'd7, 8'd2, "ovl_s7");
        step(1'b1, 1'b1, 4'd8, 8'd3, "ovl_s8");

        // Mismatch fallback
        step(1'b1, 1'b1, 4'd2, 8'd3, "mm_to_s2");
        step(1'b1, 1'b1, 4'd2, 8'd3, "mm_s2_b1");
        step(1'b1, 1'b0, 4'd3, 8'd3, "mm_to_s3");
        step(1'b1, 1'b0, 4'd0, 8'd3, "mm_s3_b0");
        step(1'b1, 1'b1, 4'd1, 8'd3, "mm_to_s1");
        step(1'b1, 1'b0, 4'd0, 8'd3, "mm_s1_b0");
        step(1'b1, 1'b1, 4'd1, 8'd3, "mm_b1");
        step(1'b1, 1'b1, 4'd2, 8'd3, "mm_b2");
        step(1'b1, 1'b0, 4'd3, 8'd3, "mm_b3");
        step(1'b1, 1'b1, 4'd4, 8'd3, "mm_b4");
        step(1'b1, 1'b0, 4'd5, 8'd3, "mm_b5");
        step(1'b1, 1'b0, 4'd6, 8'd3, "mm_b6");
        step(1'b1, 1'b1, 4'd7, 8'd3, "mm_b7");
        step(1'b1, 1'b0, 4'd0, 8'd3, "mm_s7_b0");

        // Valid gating, then Clear wins over a valid bit
        step(1'b1, 1'b1, 4'd1, 8'd3, "gate_v1");
        step(1'b0, 1'b0, 4'd1, 8'd3, "gate_hold1");
        step(1'b0, 1'b1, 4'd1, 8'd3, "gate_hold2");
        step(1'b1, 1'b1, 4'd2, 8'd3, "gate_v2");
        step(1'b0, 1'b1, 4'd2, 8'd3, "gate_hold3");
        step(1'b0, 1'b0, 4'd2, 8'd3, "gate_hold4");
        step(1'b1, 1'b0, 4'd3, 8'd3, "gate_v3");
        @(negedge clk); #1;
        drive_push(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, "clear");
        step(1'b0, 1'b0, 4'd0, 8'd0, "after_clear");

        // Asynchronous reset between edges while in S5
        full_match(8'd0, "pre_rst");
        step(1'b1, 1'b0, 4'd3, 8'd1, "to_s3");
        step(1'b1, 1'b1, 4'd4, 8'd1, "to_s4");
        step(1'b1, 1'b0, 4'd5, 8'd1, "to_s5");
        @(negedge clk); v0 = 1'b0; #2;
        rst_n = 1'b0; #1;
        check4("async_rst.state", st0, 4'd0);
        check8("async_rst.count", cnt0, 8'd0);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 4'd0, 8'd0, "post_rst_hold");

        // Illegal encoding recovers to S0, count kept, bit ignored
        full_match(8'd0, "pre_ill");
        @(negedge clk); #1;
        force dut.r_state = 4'd12;
        #1 release dut.r_state;
        drive_push(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 8'd1, "illegal");
        step(1'b1, 1'b1, 4'd1, 8'd1, "post_ill");

        // Saturation with a uniform pattern
        for (int i = 1; i <= 300; i++) begin
            n = i - 7;
            if (n < 0) n = 0;
            if (n > 255) n = 255;
            @(negedge clk); #1;
            drive_push(1'b1, 1'b0, 1'b1, 1'b1, (i >= 8) ? 4'd8 : 4'(i), 8'(n), "sat");
        end

        @(negedge clk); #1;
        v1 = 1'b0; v0 = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/moore_state_encoder.md
Name: moore_state_encoder

Overview:
- Next-state logic and state register of the Lab2 Moore sequence detector. It is the writer of the 4-bit State bus consumed by the Moore output decoder.
- Samples a serial bit stream and tracks how many leading bits of an 8-bit target pattern are currently matched, with overlap allowed.
- S8 means full match. The decoder asserts its output in S8.
- Also keeps a saturating count of completed matches for the lab display.

Parameters:
- PATTERN, 8'b11010011, target sequence, transmitted MSB (bit 7) first.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Clear  input  1  synchronous clear of State and Match_Count.
- In_Valid  input  1  In_Bit is sampled on this edge when 1.
- In_Bit  input  1  serial data bit.
- State  output  4  registered state S0..S8 (4'd0..4'd8) = number of pattern bits currently matched.
- Match_Count  output  8  number of entries into S8, saturating.

Behaviour:
- Clocking and reset:
  - One clock, Clk.
  - Reset is asynchronous and active-low: Reset_n=0 immediately forces State=S0 and Match_Count=0, independent of Clk.
  - Reset deasserting mid-stream restarts matching from S0. No partial history is kept.
- Priority at each rising edge, highest first:
  1. Clear=1: State<=S0, Match_Count<=0, regardless of In_Valid or the current state.
  2. State in S9..S15 (illegal): State<=S0, Match_Count unchanged, In_Bit ignored even if In_Valid=1.
  3. In_Valid=1: State<=next(State, In_Bit).
  4. Otherwise: State and Match_Count hold.
- Prefix definitions:
  - Prefix of length k is PATTERN[7:8-k]. The empty prefix has k=0.
  - The matched string for state k is that prefix.
- next(k, b), for k in 0..8:
  - Let w = prefix(k) followed by b. For k=8, w = the full pattern followed by b.
  - Result = length of the longest suffix of w that is also a prefix of PATTERN, with length at most 8.
  - From S8 the proper-suffix rule provides overlap: a trailing partial match is kept, not discarded.
  - Implement as a function or a case over PATTERN. It must be correct for any 8-bit PATTERN value, not just the default.
- Match_Count:
  - Increments by 1 on an edge where rule 3 applies and next(...)==S8.
  - This includes S8 to S8 transitions, which are possible only for uniform patterns.
  - Saturates at 8'd255: no wrap to 0.
- Latency:
  - State reflects the bit sampled at edge n immediately after edge n.
  - The decoder output is therefore high during the cycle after the final pattern bit is sampled.
  - Match_Count updates on the same edge that State enters S8.
- Output is Moore-type: State is purely registered, with no combinational path from In_Bit or In_Valid to State.
- In_Valid low for any number of cycles freezes matching. Bits are not lost or duplicated.

Test Plan:
- Full match: reset, then In_Valid=1 with bits 1,1,0,1,0,0,1,1 on consecutive edges.
  - Required: State sequence 1,2,3,4,5,6,7,8.
  - Required: Match_Count=1.
- Overlap from S8:
  - Bit 1 -> S2 ("11" retained).
  - From a fresh S8, bit 0 -> S3 ("110" retained).
  - From S3, bits 1,0,0,1,1 -> S8 again, Match_Count=2.
- Mismatch fallback:
  - From S2, bit 1 -> S2.
  - From S3, bit 0 -> S0.
  - From S1, bit 0 -> S0.
  - From S7, bit 0 -> S0.
- Valid gating and Clear:
  - Send 1,1,0 with In_Valid pulsed on only every third cycle -> State=S3, with holds in between.
  - Then assert Clear together with In_Valid=1, In_Bit=1 -> State=S0 and Match_Count=0 on that edge.
- Reset and illegal state:
  - Drop Reset_n between clock edges while in S5 -> State=S0 before the next edge.
  - Force State=4'd12 -> S0 on the next edge, with Match_Count unchanged.
- Saturation:
  - Run PATTERN=8'hFF with a continuous stream of 1s for 300 bits.
  - Required: State stays S8 from bit 8 onward.
  - Required: Match_Count reaches 255 and holds at 255.
